// File: rtl/npu_hazard_decoder.sv
// npu_hazard_decoder: registered instruction decode with issue-slot history, per-operand
// forwarding select/kind, and optional load-use interlock (NPU_DEC_INTERLOCK_EN).

module npu_hazard_match #(
  parameter int HIST_DEPTH = 4,
  parameter int SEL_W      = 3
) (
  input  logic                           i_en,
  input  logic                           i_vec,
  input  logic [3:0]                     i_reg,
  input  logic [HIST_DEPTH-1:0]          i_hv,
  input  logic [HIST_DEPTH-1:0][2:0]     i_hop,
  input  logic [HIST_DEPTH-1:0][3:0]     i_hrd,
  output logic [SEL_W-1:0]               o_sel,
  output logic [1:0]                     o_kind
);
  // Scan oldest to newest so the nearest producer overwrites any older one.
  // Producers are exactly the opcodes with bit0 clear; bit2 picks the vector file.
  always_comb begin
    o_sel  = '0;
    o_kind = '0;
    for (int k = HIST_DEPTH-1; k >= 0; k--) begin
      if (i_en && i_hv[k] && !i_hop[k][0] && (i_hop[k][2] == i_vec) && (i_hrd[k] == i_reg)) begin
        o_sel  = SEL_W'(k+1);
        o_kind = i_hop[k][2:1];
      end
    end
  end
endmodule

module npu_hazard_decoder #(
  parameter int HIST_DEPTH = 4,
  parameter int LOAD_LAT   = 2,
  parameter int VLOAD_LAT  = 2,
  localparam int SEL_W     = $clog2(HIST_DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      inst_i,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2:0]       opcode_o,
  output logic [3:0]       rd_o,
  output logic [3:0]       rs1_o,
  output logic [3:0]       rs2_o,
  output logic             func_o,
  output logic [4:0]       short_imm_o,
  output logic [7:0]       long_imm_o,
  output logic [SEL_W-1:0] fwd_rs1_sel_o,
  output logic [SEL_W-1:0] fwd_rs2_sel_o,
  output logic [1:0]       fwd_rs1_kind_o,
  output logic [1:0]       fwd_rs2_kind_o,
  output logic             illegal_o,
  output logic             stall_o
);
`ifdef NPU_DEC_INTERLOCK_EN
  localparam logic IL_EN = 1'b1;
`else
  localparam logic IL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]       op;
    logic [3:0]       rd;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic             func;
    logic [4:0]       simm;
    logic [7:0]       limm;
    logic [SEL_W-1:0] s1;
    logic [SEL_W-1:0] s2;
    logic [1:0]       k1;
    logic [1:0]       k2;
    logic             ill;
  } dec_t;

  logic [2:0]             w_op;
  logic [1:0]             w_en, w_vec, w_haz;
  logic [1:0][3:0]        w_reg;
  logic [1:0][SEL_W-1:0]  w_sel;
  logic [1:0][1:0]        w_kind;
  logic                   w_adv, w_acc;
  dec_t                   w_dec;

  dec_t                       r_dec;
  logic                       r_ov;
  logic [HIST_DEPTH-1:0]      r_hv;
  logic [HIST_DEPTH-1:0][2:0] r_hop;
  logic [HIST_DEPTH-1:0][3:0] r_hrd;

  assign w_op     = inst_i[15:13];
  assign w_reg[0] = inst_i[8:5];
  assign w_reg[1] = inst_i[4:1];

  // Operand 0 is rs1 (always scalar), operand 1 is rs2 (scalar for STORE, vector otherwise).
  always_comb begin
    w_en  = '0;
    w_vec = '0;
    case (w_op)
      3'b000, 3'b100: w_en = 2'b01;
      3'b001:         w_en = 2'b11;
      3'b101, 3'b110: begin w_en = 2'b11; w_vec = 2'b10; end
      default: ;
    endcase
  end

  for (genvar j = 0; j < 2; j++) begin : g_opnd
    npu_hazard_match #(.HIST_DEPTH(HIST_DEPTH), .SEL_W(SEL_W)) u_match (
      .i_en   (w_en[j]),
      .i_vec  (w_vec[j]),
      .i_reg  (w_reg[j]),
      .i_hv   (r_hv),
      .i_hop  (r_hop),
      .i_hrd  (r_hrd),
      .o_sel  (w_sel[j]),
      .o_kind (w_kind[j])
    );
    assign w_haz[j] = ((w_kind[j] == 2'b00) && (w_sel[j] != '0) && (w_sel[j] < SEL_W'(LOAD_LAT))) ||
                      ((w_kind[j] == 2'b10) && (w_sel[j] < SEL_W'(VLOAD_LAT)));
  end

  assign w_adv        = out_ready_i | ~r_ov;
  assign stall_o      = IL_EN & inst_valid_i & (|w_haz);
  assign inst_ready_o = w_adv & ~stall_o;
  assign w_acc        = inst_valid_i & inst_ready_o;

  always_comb begin
    w_dec      = '0;
    w_dec.op   = w_op;
    w_dec.rd   = inst_i[12:9];
    w_dec.rs1  = inst_i[8:5];
    w_dec.rs2  = inst_i[4:1];
    w_dec.func = inst_i[0];
    w_dec.simm = inst_i[4:0];
    w_dec.limm = inst_i[8:1];
    w_dec.s1   = w_sel[0];
    w_dec.s2   = w_sel[1];
    w_dec.k1   = w_kind[0];
    w_dec.k2   = w_kind[1];
    w_dec.ill  = (w_op == 3'b011) || (w_op == 3'b111);
  end

  // History moves only on advancing slots, so backpressure never ages a producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= '0;
      r_ov  <= 1'b0;
      r_hv  <= '0;
      r_hop <= '0;
      r_hrd <= '0;
    end else if (w_adv) begin
      r_ov <= w_acc;
      if (w_acc) r_dec <= w_dec;
      for (int k = HIST_DEPTH-1; k >= 1; k--) begin
        r_hv[k]  <= r_hv[k-1];
        r_hop[k] <= r_hop[k-1];
        r_hrd[k] <= r_hrd[k-1];
      end
      r_hv[0]  <= w_acc;
      r_hop[0] <= w_op;
      r_hrd[0] <= inst_i[12:9];
    end
  end

  assign out_valid_o    = r_ov;
  assign opcode_o       = r_dec.op;
  assign rd_o           = r_dec.rd;
  assign rs1_o          = r_dec.rs1;
  assign rs2_o          = r_dec.rs2;
  assign func_o         = r_dec.func;
  assign short_imm_o    = r_dec.simm;
  assign long_imm_o     = r_dec.limm;
  assign fwd_rs1_sel_o  = r_dec.s1;
  assign fwd_rs2_sel_o  = r_dec.s2;
  assign fwd_rs1_kind_o = r_dec.k1;
  assign fwd_rs2_kind_o = r_dec.k2;
  assign illegal_o      = r_dec.ill;
endmodule

// File: tb/tb_npu_hazard_decoder.sv
// Directed bench for npu_hazard_decoder: vector table for forwarding streams plus
// hand sequences for load-use stall, backpressure and reset.
module tb_npu_hazard_decoder;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      inst_i = '0;
  logic             inst_valid_i = 1'b0;
  logic             out_ready_i = 1'b1;
  logic             inst_ready_o, out_valid_o, func_o, illegal_o, stall_o;
  logic [2:0]       opcode_o;
  logic [3:0]       rd_o, rs1_o, rs2_o;
  logic [4:0]       short_imm_o;
  logic [7:0]       long_imm_o;
  logic [SEL_W-1:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
  logic [1:0]       fwd_rs1_kind_o, fwd_rs2_kind_o;

  npu_hazard_decoder #(.HIST_DEPTH(4), .LOAD_LAT(2), .VLOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .func_o(func_o),
    .short_imm_o(short_imm_o), .long_imm_o(long_imm_o),
    .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
    .fwd_rs1_kind_o(fwd_rs1_kind_o), .fwd_rs2_kind_o(fwd_rs2_kind_o),
    .illegal_o(illegal_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inst;
    logic        v;
    int          ov, op, s1, k1, s2, k2, ill;
  } vec_t;

  vec_t tbl[$];
  int   ncmp = 0;
  int   nerr = 0;

  function automatic vec_t mk(int inst, int v, int ov, int op, int s1, int k1, int s2, int k2, int ill);
    vec_t r;
    r.inst = 16'(inst); r.v = (v != 0);
    r.ov = ov; r.op = op; r.s1 = s1; r.k1 = k1; r.s2 = s2; r.k2 = k2; r.ill = ill;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One slot: drive at negedge, check combinational handshake, then step past posedge.
  task automatic cyc(logic [15:0] inst, bit v, bit rdy, int est, int erdy, string tag);
    @(negedge clk);
    inst_i = inst; inst_valid_i = v; out_ready_i = rdy;
    #1;
    chk({tag, ".stall"}, int'(stall_o), est);
    chk({tag, ".ready"}, int'(inst_ready_o), erdy);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string tag, int ov, int op, int s1, int k1, int s2, int k2, int ill);
    chk({tag, ".ov"},  int'(out_valid_o), ov);
    chk({tag, ".op"},  int'(opcode_o), op);
    chk({tag, ".s1"},  int'(fwd_rs1_sel_o), s1);
    chk({tag, ".k1"},  int'(fwd_rs1_kind_o), k1);
    chk({tag, ".s2"},  int'(fwd_rs2_sel_o), s2);
    chk({tag, ".k2"},  int'(fwd_rs2_kind_o), k2);
    chk({tag, ".ill"}, int'(illegal_o), ill);
  endtask

  task automatic chk_zero(string tag);
    chk_out(tag, 0, 0, 0, 0, 0, 0, 0);
    chk({tag, ".rd"},   int'(rd_o), 0);
    chk({tag, ".rs1"},  int'(rs1_o), 0);
    chk({tag, ".rs2"},  int'(rs2_o), 0);
    chk({tag, ".func"}, int'(func_o), 0);
    chk({tag, ".simm"}, int'(short_imm_o), 0);
    chk({tag, ".limm"}, int'(long_imm_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; inst_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // inputs/expected: inst, valid | out_valid, opcode, sel1, kind1, sel2, kind2, illegal
    tbl.push_back(mk('h4600, 1, 1, 2, 0, 0, 0, 0, 0)); // MOV r3
    tbl.push_back(mk('h206A, 1, 1, 1, 1, 1, 0, 0, 0)); // STORE r3,r5
    for (int i = 0; i < 4; i++) tbl.push_back(mk('h0000, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk('h8200, 1, 1, 4, 0, 0, 0, 0, 0)); // VLOAD v1
    tbl.push_back(mk('h4200, 1, 1, 2, 0, 0, 0, 0, 0)); // MOV r1
    tbl.push_back(mk('hC022, 1, 1, 6, 1, 1, 2, 2, 0)); // VMAC rs1=r1 rs2=v1
    for (int i = 0; i < 4; i++) tbl.push_back(mk('h0000, 0, 0, 6, 1, 1, 2, 2, 0));
    tbl.push_back(mk('h4E00, 1, 1, 2, 0, 0, 0, 0, 0)); // MOV r7
    tbl.push_back(mk('h4E00, 1, 1, 2, 0, 0, 0, 0, 0)); // MOV r7
    tbl.push_back(mk('h20EE, 1, 1, 1, 1, 1, 1, 1, 0)); // STORE r7,r7 -> nearest
    for (int i = 0; i < 4; i++) tbl.push_back(mk('h0000, 0, 0, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk('h20EE, 1, 1, 1, 0, 0, 0, 0, 0)); // history aged out
    tbl.push_back(mk('h5E00, 1, 1, 2, 0, 0, 0, 0, 0)); // MOV r15
    tbl.push_back(mk('hFFFF, 1, 1, 7, 0, 0, 0, 0, 1)); // illegal: no reads
    tbl.push_back(mk('h21FE, 1, 1, 1, 2, 1, 2, 1, 0)); // illegal is not a producer

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_zero("reset");
    chk("reset.stall", int'(stall_o), 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("row%0d", i);
      cyc(tbl[i].inst, tbl[i].v, 1'b1, 0, 1, t);
      chk_out(t, tbl[i].ov, tbl[i].op, tbl[i].s1, tbl[i].k1, tbl[i].s2, tbl[i].k2, tbl[i].ill);
    end
    chk("row23.rs1",  int'(rs1_o), 15);
    chk("row23.rs2",  int'(rs2_o), 15);
    chk("row23.func", int'(func_o), 0);
    chk("row23.simm", int'(short_imm_o), 30);
    chk("row23.limm", int'(long_imm_o), 255);

    // Asynchronous reset mid-stream, with a would-be consumer on the input.
    @(negedge clk);
    inst_i = 16'h0840; inst_valid_i = 1'b1; #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    chk("arst.stall", int'(stall_o), 0);
    @(negedge clk);
    rst_n = 1'b1; inst_valid_i = 1'b0;

    // LOAD r2 then LOAD r4 <- r2 back-to-back.
    cyc(16'h0400, 1'b1, 1'b1, 0, 1, "lu.ld");
    chk_out("lu.ld", 1, 0, 0, 0, 0, 0, 0);
`ifdef NPU_DEC_INTERLOCK_EN
    cyc(16'h0840, 1'b1, 1'b1, 1, 0, "lu.stall");
    chk_out("lu.bubble", 0, 0, 0, 0, 0, 0, 0);
    cyc(16'h0840, 1'b1, 1'b1, 0, 1, "lu.use");
    chk_out("lu.use", 1, 0, 2, 0, 0, 0, 0);
    chk("lu.use.rd", int'(rd_o), 4);
`else
    cyc(16'h0840, 1'b1, 1'b1, 0, 1, "lu.use");
    chk_out("lu.use", 1, 0, 1, 0, 0, 0, 0);
    chk("lu.use.rd", int'(rd_o), 4);
`endif

    // Backpressure after LOAD r2 freezes history; the consumer still sees distance 1.
    do_reset();
    cyc(16'h0400, 1'b1, 1'b1, 0, 1, "bp.ld");
    chk_out("bp.ld", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      string t;
      t = $sformatf("bp.hold%0d", i);
`ifdef NPU_DEC_INTERLOCK_EN
      cyc(16'h0840, 1'b1, 1'b0, 1, 0, t);
`else
      cyc(16'h0840, 1'b1, 1'b0, 0, 0, t);
`endif
      chk({t, ".ov"}, int'(out_valid_o), 1);
      chk({t, ".rd"}, int'(rd_o), 2);
    end
`ifdef NPU_DEC_INTERLOCK_EN
    cyc(16'h0840, 1'b1, 1'b1, 1, 0, "bp.stall");
    chk_out("bp.bubble", 0, 0, 0, 0, 0, 0, 0);
    cyc(16'h0840, 1'b1, 1'b1, 0, 1, "bp.use");
    chk_out("bp.use", 1, 0, 2, 0, 0, 0, 0);
`else
    cyc(16'h0840, 1'b1, 1'b1, 0, 1, "bp.use");
    chk_out("bp.use", 1, 0, 1, 0, 0, 0, 0);
`endif
    chk("bp.use.rd", int'(rd_o), 4);
    cyc(16'h0000, 1'b0, 1'b1, 0, 1, "bp.idle");
    chk("bp.idle.ov", int'(out_valid_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/npu_hazard_decoder.md
# npu_hazard_decoder

Registered, handshaked instruction decoder for the NPU front end that tracks the last `HIST_DEPTH` issue slots and reports per-operand forwarding sources with a distance. Distance is counted in issue slots. The block optionally interlocks on load-use hazards by inserting bubbles. It sits between instruction fetch and the scalar/vector execute pipes, and drives the operand bypass muxes.

## Interface
- `HIST_DEPTH`, 4: issue slots tracked; legal range 1..8.
- `LOAD_LAT`, 2: minimum distance at which a scalar LOAD result is forwardable; 1..`HIST_DEPTH`.
- `VLOAD_LAT`, 2: same rule for VLOAD results; 1..`HIST_DEPTH`.
- Derived: `SEL_W` = $clog2(`HIST_DEPTH`+1).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inst_i` in 16: instruction. Fields: opcode[15:13], rd[12:9], rs1[8:5], rs2[4:1], func[0], short_imm[4:0], long_imm[8:1].
- `inst_valid_i` in 1 / `inst_ready_o` out 1: input handshake.
- `out_valid_o` out 1 / `out_ready_i` in 1: output handshake.
- `opcode_o` 3, `rd_o` 4, `rs1_o` 4, `rs2_o` 4, `func_o` 1, `short_imm_o` 5, `long_imm_o` 8: registered decoded fields.
- `fwd_rs1_sel_o`, `fwd_rs2_sel_o` out `SEL_W`: 0 selects the register file; k selects the result of the instruction issued k slots earlier.
- `fwd_rs1_kind_o`, `fwd_rs2_kind_o` out 2: producer class. 00 LOAD, 01 MOV, 10 VLOAD, 11 VMAC.
- `illegal_o` out 1: opcode 011 or 111.
- `stall_o` out 1: combinational; an interlock is active this cycle.

## Operation
- Opcodes: LOAD 000, STORE 001, MOV 010, VLOAD 100, VSTORE 101, VMAC 110.
- Scalar producers are LOAD and MOV; they write scalar rd.
- Vector producers are VLOAD and VMAC; they write vector rd.
- Scalar reads:
  - STORE reads rs1 and rs2.
  - LOAD, VLOAD, VSTORE and VMAC read rs1.
- Vector reads: VSTORE and VMAC read rs2.
- An illegal opcode produces no reads, no writes, and is never flagged for forwarding.
- History: `HIST_DEPTH` entries of {valid, opcode, rd}. Entry 1 is the most recent issue slot.
- Match rule per operand:
  - Scan entries 1..`HIST_DEPTH`.
  - An entry matches only if it is valid, its producer class matches the operand's file (scalar or vector), and its rd equals the operand.
  - The smallest matching distance wins; sel = distance, kind = producer class.
  - No match gives sel 0 and kind 00.
  - Operands that are not read give sel 0 and kind 00.
- Hazard: a winning match has kind LOAD with distance < `LOAD_LAT`, or kind VLOAD with distance < `VLOAD_LAT`.
- advance = `out_ready_i` | !`out_valid_o`.
- `stall_o` = `inst_valid_i` & hazard.
- `inst_ready_o` = advance & !`stall_o`.
- On each advance cycle:
  - If accept (`inst_valid_i` & `inst_ready_o`): load the output register with decoded fields, fwd and illegal; set `out_valid_o` to 1; shift {1, opcode, rd} into history.
  - Otherwise (idle or stall bubble): set `out_valid_o` to 0 and shift an invalid entry into history. The data fields hold their last values.
- No advance: the output register and history hold.
- Entry `HIST_DEPTH` falls off on every shift.
- Fwd values are computed from history before that cycle's shift.

## Timing
- Reset: every output register is 0, all history entries are invalid, and `out_valid_o` is 0.
- Reset mid-stall drops the held instruction, which fetch must re-present.
- Latency: one cycle from accept to `out_valid_o`.
- Throughput: one instruction per cycle when there are no hazards and `out_ready_i` is 1.
- A stall inserts (`LOAD_LAT` − d) bubbles. The instruction stays on `inst_i` and is accepted on the first advance cycle after the hazard clears. At that point its sel equals `LOAD_LAT` (or `VLOAD_LAT`).
- Downstream backpressure (`out_ready_i` = 0 with `out_valid_o` = 1) freezes history. Stall bubbles therefore count only advancing slots.
- Fetch must hold `inst_i` stable while `inst_valid_i` = 1 and `inst_ready_o` = 0.

## Configuration
- `NPU_DEC_INTERLOCK_EN` defined: load-use interlock exactly as above.
- Undefined:
  - `stall_o` is tied to 0 and `inst_ready_o` = advance.
  - Bubbles are only produced when the input is idle.
  - sel/kind are still reported; hazards are the compiler's responsibility.

## Test plan
- MOV r3 (16'h4600), then STORE rs1=r3, rs2=r5 (16'h206A) back-to-back -> second output has `fwd_rs1_sel_o`=1, kind 01, `fwd_rs2_sel_o`=0.
- LOAD rd=r2 (16'h0400), then LOAD rd=r4, rs1=r2 (16'h0840), `LOAD_LAT`=2, interlock on -> one cycle with `stall_o`=1 and `inst_ready_o`=0, one bubble with `out_valid_o`=0, then the second LOAD issues with sel=2 and kind 00. With interlock off -> no stall, sel=1.
- VLOAD v1, then MOV r1, then VMAC rs2=v1 -> rs2 sel=2, kind 10 (the scalar MOV r1 is ignored); rs1 matches MOV r1 at distance 1, kind 01.
- MOV r7 issued twice, then STORE reading r7 -> sel=1 (nearest wins). After `HIST_DEPTH` idle advance cycles, the same STORE gives sel=0.
- Hold `out_ready_i`=0 for 3 cycles after LOAD r2, then present a consumer of r2 -> history is frozen, stall is still counted against distance 1, and the bubble count is unchanged by the backpressure.
- Opcode 111 input -> `illegal_o`=1, all sel 0; assert `rst_n` mid-stream -> all outputs 0 the same cycle.
